// File: rtl/mpu_int_ctrl.sv
// rtl/mpu_int_ctrl.sv - fixed-priority interrupt controller between N MPU channels and the main processor
//
// Latches each channel's request word, holds the channel off (en=0) while it
// is pending or in service, and presents one request at a time to the
// processor. Release is by ack or, when TIMEOUT > 0, by auto-commit.
//
// Ports:
//   sys_clk   clock, rising edge
//   sys_rst   synchronous active-high reset
//   irq       per-channel request
//   data      per-channel word, channel c at [c*DATA_W +: DATA_W]
//   en        1 = channel idle and may raise a new request
//   mask      1 = channel excluded from arbitration
//   irq_out   request to processor, high while a channel is in service
//   irq_id    index of in-service channel
//   irq_data  latched word of in-service channel
//   ack       commit from processor
//   timeout   one-cycle pulse after an auto-commit
//   lost      sticky per-channel flag: request arrived while en=0
//   lost_clr  per-bit clear of lost
module mpu_int_ctrl #(
    parameter int N_CH    = 4,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 4,
    localparam int ID_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [N_CH-1:0]          irq,
    input  logic [N_CH*DATA_W-1:0]   data,
    output logic [N_CH-1:0]          en,
    input  logic [N_CH-1:0]          mask,
    output logic                     irq_out,
    output logic [ID_W-1:0]          irq_id,
    output logic [DATA_W-1:0]        irq_data,
    input  logic                     ack,
    output logic                     timeout,
    output logic [N_CH-1:0]          lost,
    input  logic [N_CH-1:0]          lost_clr
);

    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST_C = TO_LAST[CNT_W-1:0];

    logic [N_CH-1:0]   r_pend;
    logic [DATA_W-1:0] r_buf [N_CH];
    logic [N_CH-1:0]   r_lost;
    logic              r_irq_out;
    logic [ID_W-1:0]   r_irq_id;
    logic [DATA_W-1:0] r_irq_data;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_cnt;

    logic [N_CH-1:0]   w_serv_oh;
    logic [N_CH-1:0]   w_en;
    logic [N_CH-1:0]   w_new_req;
    logic [N_CH-1:0]   w_lost_set;
    logic [N_CH-1:0]   w_cand;
    logic              w_sel_any;
    logic [ID_W-1:0]   w_sel_id;
    logic [N_CH-1:0]   w_sel_oh;

    // The in-service channel is encoded by irq_out/irq_id rather than a
    // separate per-channel state bit.
    assign w_serv_oh  = r_irq_out ? (N_CH'(1) << r_irq_id) : '0;
    assign w_en       = ~(r_pend | w_serv_oh);
    assign w_new_req  = irq & w_en;
    assign w_lost_set = irq & ~w_en;

    // Arbitration only happens while nothing is in service.
    assign w_cand = r_pend & ~mask & {N_CH{~r_irq_out}};

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        w_sel_any = 1'b0;
        w_sel_id  = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (w_cand[c]) begin
                w_sel_any = 1'b1;
                w_sel_id  = ID_W'(c);
            end
        end
    end

    assign w_sel_oh = w_sel_any ? (N_CH'(1) << w_sel_id) : '0;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_pend     <= '0;
            r_lost     <= '0;
            r_irq_out  <= 1'b0;
            r_irq_id   <= '0;
            r_irq_data <= '0;
            r_timeout  <= 1'b0;
            r_cnt      <= '0;
            for (int c = 0; c < N_CH; c++) begin
                r_buf[c] <= '0;
            end
        end else begin
            r_pend <= (r_pend & ~w_sel_oh) | w_new_req;
            for (int c = 0; c < N_CH; c++) begin
                if (w_new_req[c]) begin
                    r_buf[c] <= data[c*DATA_W +: DATA_W];
                end
            end
            // A new loss event overrides a clear on the same edge.
            r_lost    <= (r_lost & ~lost_clr) | w_lost_set;
            r_timeout <= 1'b0;

            if (r_irq_out) begin
                if (ack) begin
                    r_irq_out <= 1'b0;
                end else if (TIMEOUT > 0 && r_cnt == TO_LAST_C) begin
                    r_irq_out <= 1'b0;
                    r_timeout <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_sel_any) begin
                r_irq_out  <= 1'b1;
                r_irq_id   <= w_sel_id;
                r_irq_data <= r_buf[w_sel_id];
                r_cnt      <= '0;
            end
        end
    end

    assign en       = w_en;
    assign irq_out  = r_irq_out;
    assign irq_id   = r_irq_id;
    assign irq_data = r_irq_data;
    assign timeout  = r_timeout;
    assign lost     = r_lost;

endmodule

// File: tb/tb_mpu_int_ctrl.sv
// tb/tb_mpu_int_ctrl.sv - directed self-checking bench for mpu_int_ctrl
module tb_mpu_int_ctrl;

    localparam int N  = 4;
    localparam int DW = 64;

    logic            sys_clk = 1'b0;
    logic            sys_rst;
    logic [N-1:0]    irq;
    logic [N*DW-1:0] data;
    logic [N-1:0]    mask;
    logic            ack;
    logic [N-1:0]    lost_clr;

    logic [N-1:0]    en,       en2;
    logic            irq_out,  irq_out2;
    logic [1:0]      irq_id,   irq_id2;
    logic [DW-1:0]   irq_data, irq_data2;
    logic            timeout,  timeout2;
    logic [N-1:0]    lost,     lost2;

    int n_tests = 0;
    int n_fail  = 0;

    mpu_int_ctrl #(.N_CH(N), .DATA_W(DW), .TIMEOUT(4)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .irq(irq), .data(data), .en(en),
        .mask(mask), .irq_out(irq_out), .irq_id(irq_id), .irq_data(irq_data),
        .ack(ack), .timeout(timeout), .lost(lost), .lost_clr(lost_clr)
    );

    // Second instance with the timeout disabled, sharing all inputs.
    mpu_int_ctrl #(.N_CH(N), .DATA_W(DW), .TIMEOUT(0)) u_dut_nt (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .irq(irq), .data(data), .en(en2),
        .mask(mask), .irq_out(irq_out2), .irq_id(irq_id2), .irq_data(irq_data2),
        .ack(ack), .timeout(timeout2), .lost(lost2), .lost_clr(lost_clr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        irq = '0; data = '0; mask = '0; ack = 1'b0; lost_clr = '0;
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (en !== 4'hF) begin n_fail++; $display("FAIL reset_en got %h exp f", en); end
        n_tests++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL reset_irq_out got %b exp 0", irq_out); end
        n_tests++; if (irq_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got %0d exp 0", irq_id); end
        n_tests++; if (irq_data !== 64'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", irq_data); end
        n_tests++; if (timeout !== 1'b0 || lost !== 4'h0) begin n_fail++; $display("FAIL reset_to_lost got %b/%h exp 0/0", timeout, lost); end
        // ack with nothing in service must do nothing
        ack = 1'b1; tick(); ack = 1'b0;
        n_tests++; if (irq_out !== 1'b0 || en !== 4'hF) begin n_fail++; $display("FAIL idle_ack got %b/%h exp 0/f", irq_out, en); end
    endtask

    task automatic test_single();
        do_reset();
        irq = 4'b0100;
        data[2*DW +: DW] = 64'hDEAD_BEEF_0000_0002;
        tick();
        irq = '0;
        n_tests++; if (en !== 4'b1011) begin n_fail++; $display("FAIL single_en got %b exp 1011", en); end
        n_tests++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL single_early got %b exp 0", irq_out); end
        tick();
        n_tests++; if (irq_out !== 1'b1 || irq_id !== 2'd2) begin n_fail++; $display("FAIL single_sel got %b/%0d exp 1/2", irq_out, irq_id); end
        n_tests++; if (irq_data !== 64'hDEAD_BEEF_0000_0002) begin n_fail++; $display("FAIL single_data got %h exp deadbeef00000002", irq_data); end
        ack = 1'b1; tick(); ack = 1'b0;
        n_tests++; if (irq_out !== 1'b0 || en !== 4'hF) begin n_fail++; $display("FAIL single_ack got %b/%h exp 0/f", irq_out, en); end
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL single_no_to got %b exp 0", timeout); end
        n_tests++; if (irq_id !== 2'd2 || irq_data !== 64'hDEAD_BEEF_0000_0002) begin n_fail++; $display("FAIL single_hold got %0d/%h exp 2/deadbeef00000002", irq_id, irq_data); end
    endtask

    task automatic test_order();
        int order [3] = '{0, 1, 3};
        logic [N-1:0] exp_en;
        int w;
        do_reset();
        irq = 4'b1011;
        for (int c = 0; c < N; c++) data[c*DW +: DW] = 64'h100 + 64'(c);
        tick();
        irq = '0;
        exp_en = 4'b0100;
        n_tests++; if (en !== exp_en) begin n_fail++; $display("FAIL order_en0 got %b exp %b", en, exp_en); end
        for (int i = 0; i < 3; i++) begin
            w = 0;
            tick();
            while (!irq_out && w < 6) begin tick(); w++; end
            n_tests++; if (w !== 0) begin n_fail++; $display("FAIL order_gap%0d got %0d extra cycles exp 0", i, w); end
            n_tests++; if (irq_id !== 2'(order[i])) begin n_fail++; $display("FAIL order_id%0d got %0d exp %0d", i, irq_id, order[i]); end
            n_tests++; if (irq_data !== 64'h100 + 64'(order[i])) begin n_fail++; $display("FAIL order_data%0d got %h exp %h", i, irq_data, 64'h100 + 64'(order[i])); end
            tick();
            ack = 1'b1; tick(); ack = 1'b0;
            exp_en = exp_en | (4'b0001 << order[i]);
            n_tests++; if (irq_out !== 1'b0 || en !== exp_en) begin n_fail++; $display("FAIL order_ack%0d got %b/%b exp 0/%b", i, irq_out, en, exp_en); end
        end
    endtask

    task automatic test_timeout();
        int hi = 0;
        int pulses = 0;
        do_reset();
        irq = 4'b0010;
        tick();
        irq = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (irq_out) hi++;
            if (timeout) pulses++;
        end
        n_tests++; if (hi !== 4) begin n_fail++; $display("FAIL to_high got %0d cycles exp 4", hi); end
        n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL to_pulses got %0d exp 1", pulses); end
        n_tests++; if (en !== 4'hF) begin n_fail++; $display("FAIL to_en got %h exp f", en); end
    endtask

    task automatic test_lost();
        int hi = 0;
        do_reset();
        irq = 4'b0001;
        data[DW-1:0] = 64'h55;
        for (int i = 0; i < 10; i++) tick();
        irq = '0;
        n_tests++; if (irq_out2 !== 1'b1 || irq_id2 !== 2'd0) begin n_fail++; $display("FAIL lost_serv got %b/%0d exp 1/0", irq_out2, irq_id2); end
        n_tests++; if (lost2 !== 4'b0001) begin n_fail++; $display("FAIL lost_set got %b exp 0001", lost2); end
        ack = 1'b1; tick(); ack = 1'b0;
        n_tests++; if (en2 !== 4'hF || timeout2 !== 1'b0) begin n_fail++; $display("FAIL lost_ack got %h/%b exp f/0", en2, timeout2); end
        for (int i = 0; i < 4; i++) begin tick(); if (irq_out2) hi++; end
        n_tests++; if (hi !== 0) begin n_fail++; $display("FAIL lost_once got %0d extra cycles exp 0", hi); end
        lost_clr = 4'b0001; tick(); lost_clr = '0;
        n_tests++; if (lost2 !== 4'b0000) begin n_fail++; $display("FAIL lost_clr got %b exp 0000", lost2); end
    endtask

    task automatic test_mask();
        do_reset();
        mask = 4'b0001;
        irq  = 4'b0011;
        tick();
        irq = '0;
        tick();
        n_tests++; if (irq_out !== 1'b1 || irq_id !== 2'd1) begin n_fail++; $display("FAIL mask_first got %b/%0d exp 1/1", irq_out, irq_id); end
        ack = 1'b1; tick(); ack = 1'b0;
        tick();
        n_tests++; if (irq_out !== 1'b0 || en !== 4'b1110) begin n_fail++; $display("FAIL mask_hold got %b/%b exp 0/1110", irq_out, en); end
        mask = '0;
        tick();
        n_tests++; if (irq_out !== 1'b1 || irq_id !== 2'd0) begin n_fail++; $display("FAIL mask_release got %b/%0d exp 1/0", irq_out, irq_id); end
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        int hi = 0;
        do_reset();
        irq = 4'b1001;
        data[3*DW +: DW] = 64'h33;
        tick();
        irq = '0;
        tick();
        n_tests++; if (irq_out !== 1'b1 || en !== 4'b0110) begin n_fail++; $display("FAIL rmid_pre got %b/%b exp 1/0110", irq_out, en); end
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        n_tests++; if (irq_out !== 1'b0 || en !== 4'hF || irq_id !== 2'd0 || irq_data !== 64'h0 || timeout !== 1'b0 || lost !== 4'h0) begin
            n_fail++; $display("FAIL rmid_state got %b/%h/%0d/%h/%b/%h exp 0/f/0/0/0/0", irq_out, en, irq_id, irq_data, timeout, lost);
        end
        for (int i = 0; i < 8; i++) begin tick(); if (irq_out) hi++; end
        n_tests++; if (hi !== 0) begin n_fail++; $display("FAIL rmid_discard got %0d service cycles exp 0", hi); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_timeout();
        test_lost();
        test_mask();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
